// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types for the store-and-forward AXIS packet FIFO.
// Input-side FSM encoding and counter widths.
package axis_pkt_fifo_pkg;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } in_state_e;

  localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port buffer: one write port, one registered read port.
// No reset on the array so it maps onto block RAM.
module axis_pkt_fifo_ram #(
  parameter int unsigned W      = 65,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXIS packet FIFO: a packet is released only once
// its tlast beat is stored; packets longer than DEPTH are dropped whole.
module axis_pkt_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                         s_axis_aclk,
  input  logic                         s_axis_aresetn,
  input  logic                         soft_clr,
  input  logic [DATA_W-1:0]            s_axis_tdata,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [DATA_W-1:0]            m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic [$clog2(DEPTH):0]       pkt_cnt,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  in_state_e state_q, state_d;
  ptr_t      wr_ptr_q, wr_ptr_d;
  ptr_t      commit_ptr_q, commit_ptr_d;
  ptr_t      rd_ptr_q, rd_ptr_d;
  ptr_t      raddr_q, raddr_d;
  ptr_t      pkt_cnt_q, pkt_cnt_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              rdy_en_q;
  logic              ram_vld_q, ram_vld_d;
  logic              out_vld_q, out_vld_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              full;
  logic              no_commit;
  logic              in_ready;
  logic              in_hs;
  logic              wr_en;
  logic              commit;
  logic              out_take;
  logic              out_load;
  logic              ren;
  logic              pkt_done;
  logic [DATA_W:0]   ram_rdata;

  // Occupancy counts beats until they leave the output register.
  assign full      = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign no_commit = commit_ptr_q == rd_ptr_q;

  assign in_ready      = (state_q == ST_DROP) || !full || no_commit;
  assign s_axis_tready = rdy_en_q && in_ready;
  assign in_hs         = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_cnt_d   = drop_cnt_q;
    wr_en        = 1'b0;
    commit       = 1'b0;
    unique case (state_q)
      ST_PASS: begin
        if (in_hs && !full) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (s_axis_tlast) begin
            commit       = 1'b1;
            commit_ptr_d = wr_ptr_q + 1'b1;
          end
        end else if (in_hs) begin
          // Buffer full of this one packet: it can never fit.
          wr_ptr_d = commit_ptr_q;
          if (s_axis_tlast) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (in_hs && s_axis_tlast) begin
          drop_cnt_d = drop_cnt_q + 1'b1;
          state_d    = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  axis_pkt_fifo_ram #(
    .W      (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (s_axis_aclk),
    .we    (wr_en),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .re    (ren),
    .raddr (raddr_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // RAM output register doubles as the prefetch slot.
  assign out_take = out_vld_q && m_axis_tready;
  assign out_load = ram_vld_q && (!out_vld_q || out_take);
  assign ren      = (raddr_q != commit_ptr_q) &&
                    (!ram_vld_q || out_load);
  assign pkt_done = out_take && out_last_q;

  always_comb begin
    raddr_d    = raddr_q + PTR_W'(ren);
    rd_ptr_d   = rd_ptr_q + PTR_W'(out_take);
    ram_vld_d  = ren || (ram_vld_q && !out_load);
    out_vld_d  = out_load || (out_vld_q && !out_take);
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    if (out_load) begin
      out_data_d = ram_rdata[DATA_W-1:0];
      out_last_d = ram_rdata[DATA_W];
    end
    pkt_cnt_d = pkt_cnt_q + PTR_W'(commit) - PTR_W'(pkt_done);
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      rdy_en_q     <= 1'b0;
      state_q      <= ST_PASS;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      raddr_q      <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      ram_vld_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else if (soft_clr) begin
      rdy_en_q     <= 1'b1;
      state_q      <= ST_PASS;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      raddr_q      <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      ram_vld_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      rdy_en_q     <= 1'b1;
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      raddr_q      <= raddr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      ram_vld_q    <= ram_vld_d;
      out_vld_q    <= out_vld_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_vld_q;
  assign fill_level    = wr_ptr_q - rd_ptr_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo: directed packets in,
// expected beats queued by the driver, checked by a monitor.
module tb_axis_pkt_fifo;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 512;
  localparam int AW     = 9;
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              soft_clr = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tlast = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic [AW:0]       fill_level;
  logic [AW:0]       pkt_cnt;
  logic [15:0]       drop_cnt;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .soft_clr       (soft_clr),
    .s_axis_tdata   (s_tdata),
    .s_axis_tlast   (s_tlast),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tlast   (m_tlast),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .fill_level     (fill_level),
    .pkt_cnt        (pkt_cnt),
    .drop_cnt       (drop_cnt)
  );

  logic [DATA_W:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int sent_pkts = 0;
  int drained_pkts = 0;
  bit rnd_mode = 1'b0;
  bit pc_check = 1'b0;

  task automatic chk(input string nm, input logic [64:0] act,
                     input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l,
                           input bit keep);
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (s_tready) begin
        if (keep) exp_q.push_back({l, d});
        @(posedge clk);
        #1;
        if (l) sent_pkts++;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: got tready 0 expected 1 for %0h", d);
    s_tvalid = 1'b0;
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expected 0",
               nm, exp_q.size());
    end
    cycles(3);
  endtask

  initial begin
    fork
      forever begin : monitor
        logic [DATA_W:0] e;
        @(negedge clk);
        if (pc_check)
          chk("pkt_cnt_track", 65'(pkt_cnt),
              65'(sent_pkts - drained_pkts));
        if (rst_n && m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected none",
                     {m_tlast, m_tdata});
          end else begin
            e = exp_q.pop_front();
            chk("beat", {m_tlast, m_tdata}, e);
          end
          if (m_tlast) drained_pkts++;
        end
      end
      forever begin : rnd_ready
        @(posedge clk);
        #1;
        if (rnd_mode) m_tready = 1'($urandom_range(0, 1));
      end
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 65'(s_tready), 65'(0));
    chk("rst_m_tvalid", 65'(m_tvalid), 65'(0));
    chk("rst_m_tdata", {m_tlast, m_tdata}, 65'(0));
    chk("rst_fill", 65'(fill_level), 65'(0));
    chk("rst_drop", 65'(drop_cnt), 65'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(2);
    chk("post_rst_s_tready", 65'(s_tready), 65'(1));

    // 1: reset mid-packet
    m_tready = 1'b1;
    for (int b = 0; b < 3; b++) send_beat(64'h100 + 64'(b), 1'b0, 1'b0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t1_m_tvalid", 65'(m_tvalid), 65'(0));
    chk("t1_fill", 65'(fill_level), 65'(0));
    chk("t1_pkt_cnt", 65'(pkt_cnt), 65'(0));
    chk("t1_s_tready", 65'(s_tready), 65'(0));
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    chk("t1_no_output", 65'(m_tvalid), 65'(0));

    // 2: store-and-forward latency and back-to-back output
    for (int b = 1; b <= 8; b++) begin
      send_beat(64'(b), b == 8, 1'b1);
      chk("t2_hold_tvalid", 65'(m_tvalid), 65'(0));
    end
    idle();
    cycles(1);
    chk("t2_n1_tvalid", 65'(m_tvalid), 65'(0));
    for (int k = 0; k < 8; k++) begin
      cycles(1);
      chk("t2_stream_tvalid", 65'(m_tvalid), 65'(1));
    end
    wait_drain("t2");
    chk("t2_fill", 65'(fill_level), 65'(0));

    // 3: backpressure with 3 x 200-beat packets
    m_tready = 1'b0;
    for (int b = 0; b < 600; b++) begin
      if (b == 512) begin
        s_tdata  = (64'(b / 200) << 16) | 64'(b % 200);
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_s_tready_full", 65'(s_tready), 65'(0));
        chk("t3_fill", 65'(fill_level), 65'(512));
        chk("t3_pkt_cnt", 65'(pkt_cnt), 65'(2));
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
      send_beat((64'(b / 200) << 16) | 64'(b % 200),
                (b % 200) == 199, 1'b1);
    end
    idle();
    wait_drain("t3");
    chk("t3_end_fill", 65'(fill_level), 65'(0));
    chk("t3_end_pkt", 65'(pkt_cnt), 65'(0));

    // 4: oversize packet dropped whole
    m_tready = 1'b0;
    for (int b = 0; b < 600; b++)
      send_beat(64'hDEAD_0000 + 64'(b), b == 599, 1'b0);
    for (int b = 0; b < 4; b++)
      send_beat(64'hA0 + 64'(b), b == 3, 1'b1);
    idle();
    cycles(3);
    chk("t4_drop_cnt", 65'(drop_cnt), 65'(1));
    chk("t4_pkt_cnt", 65'(pkt_cnt), 65'(1));
    chk("t4_fill", 65'(fill_level), 65'(4));
    chk("t4_head", {m_tlast, m_tdata}, {1'b0, 64'hA0});
    m_tready = 1'b1;
    wait_drain("t4");
    chk("t4_end_pkt", 65'(pkt_cnt), 65'(0));

    // 5: single-beat packets with random consumer stalls
    sent_pkts    = 0;
    drained_pkts = 0;
    rnd_mode     = 1'b1;
    pc_check     = 1'b1;
    for (int p = 0; p < 200; p++)
      send_beat(64'h5000 + 64'(p), 1'b1, 1'b1);
    idle();
    wait_drain("t5");
    pc_check = 1'b0;
    rnd_mode = 1'b0;
    m_tready = 1'b1;
    cycles(2);
    chk("t5_fill", 65'(fill_level), 65'(0));

    // 6: soft clear with committed and partial packets
    m_tready = 1'b0;
    for (int b = 0; b < 10; b++)
      send_beat(64'h600 + 64'(b), (b % 4) == 3 && b < 8, 1'b0);
    idle();
    cycles(3);
    chk("t6_pre_pkt", 65'(pkt_cnt), 65'(2));
    chk("t6_pre_fill", 65'(fill_level), 65'(10));
    soft_clr = 1'b1;
    cycles(1);
    soft_clr = 1'b0;
    chk("t6_fill", 65'(fill_level), 65'(0));
    chk("t6_pkt", 65'(pkt_cnt), 65'(0));
    chk("t6_drop", 65'(drop_cnt), 65'(0));
    chk("t6_m_tvalid", 65'(m_tvalid), 65'(0));
    m_tready = 1'b1;
    for (int b = 0; b < 4; b++)
      send_beat(64'hC0 + 64'(b), b == 3, 1'b1);
    idle();
    wait_drain("t6");
    chk("t6_end_fill", 65'(fill_level), 65'(0));

    cycles(5);
    chk("sb_empty", 65'(exp_q.size()), 65'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
